// File: rtl/mul_ctrl_pkg.sv
// Shared types for the multiplier request arbiter and its response buffer.
package mul_ctrl_pkg;

  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mul_op_t;

  typedef struct packed {
    logic        id;
    mul_op_t     op;
    logic [63:0] data;
  } rsp_entry_t;

  localparam int MUL_CYCLES_DEFAULT = 4;

endpackage

// File: rtl/mul_rsp_fifo.sv
// In-order response buffer; a push into a full FIFO is accepted when the head
// is popped in the same cycle, since the write lands in the slot being freed.
module mul_rsp_fifo
  import mul_ctrl_pkg::*;
#(
  parameter  int RESP_DEPTH = 8,
  localparam int CW         = $clog2(RESP_DEPTH + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  rsp_entry_t push_data,
  input  logic       pop,
  output rsp_entry_t pop_data,
  output logic       empty,
  output logic       full,
  output logic [CW-1:0] count
);
  localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

  rsp_entry_t    mem_q [RESP_DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == CW'(RESP_DEPTH));
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    wr_d    = do_push ? ptr_inc(wr_q) : wr_q;
    rd_d    = do_pop  ? ptr_inc(rd_q) : rd_q;
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q] <= push_data;
    end
  end

  assign pop_data = mem_q[rd_q];
  assign count    = count_q;

endmodule

// File: rtl/mul_arbiter.sv
// Two-requester round-robin front end for an external pipelined multiplier.
// Issued ops are tracked by a local tag pipeline; results return in issue order.
module mul_arbiter
  import mul_ctrl_pkg::*;
#(
  parameter int CYCLES     = MUL_CYCLES_DEFAULT,
  parameter int RESP_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0][1:0]  req_op,
  input  logic [1:0][31:0] req_a,
  input  logic [1:0][31:0] req_b,
  output logic             mul_new_request,
  output logic [1:0]       mul_op,
  output logic [31:0]      mul_a,
  output logic [31:0]      mul_b,
  input  logic             mul_done,
  input  logic [1:0]       mul_completed_op,
  input  logic [63:0]      mul_p,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [1:0]       rsp_op,
  output logic [63:0]      rsp_data
);
  localparam int CW   = $clog2(RESP_DEPTH + 1);
  localparam int NSTG = CYCLES + 1;

  logic                 last_q, last_d;
  logic [CW-1:0]        outstanding_q, outstanding_d;
  logic [NSTG-1:0]      tag_vld_q;
  logic [NSTG-1:0]      tag_id_q;
  logic [NSTG-1:0][1:0] tag_op_q;

  logic          prio, gnt_id, credit_ok, issue, push, pop;
  logic          fifo_empty, fifo_full;
  logic [CW-1:0] fifo_count;
  rsp_entry_t    push_entry, head_entry;

  // Credit covers in-flight plus buffered ops, so the FIFO can never overflow.
  always_comb begin
    prio      = ~last_q;
    gnt_id    = req_valid[prio] ? prio : ~prio;
    credit_ok = (outstanding_q < CW'(RESP_DEPTH));
    issue     = (|req_valid) && credit_ok && !rst;
    last_d    = issue ? gnt_id : last_q;
  end

  assign req_ready       = issue ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
  assign mul_new_request = issue;
  assign mul_op          = req_op[gnt_id];
  assign mul_a           = req_a[gnt_id];
  assign mul_b           = req_b[gnt_id];

  assign rsp_valid = !fifo_empty && !rst;
  assign pop       = rsp_valid && rsp_ready;
  assign push      = tag_vld_q[NSTG-1];

  always_comb begin
    outstanding_d = outstanding_q;
    if (issue && !pop) begin
      outstanding_d = outstanding_q + 1'b1;
    end else if (!issue && pop) begin
      outstanding_d = outstanding_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q        <= 1'b1;
      outstanding_q <= '0;
      tag_vld_q     <= '0;
      tag_id_q      <= '0;
      tag_op_q      <= '0;
    end else begin
      last_q        <= last_d;
      outstanding_q <= outstanding_d;
      tag_vld_q[0]  <= issue;
      tag_id_q[0]   <= gnt_id;
      tag_op_q[0]   <= mul_op;
      for (int s = 1; s < NSTG; s++) begin
        tag_vld_q[s] <= tag_vld_q[s-1];
        tag_id_q[s]  <= tag_id_q[s-1];
        tag_op_q[s]  <= tag_op_q[s-1];
      end
    end
  end

  // The mul has no reset, so its result is captured purely on tag timing.
  always_comb begin
    push_entry      = '0;
    push_entry.id   = tag_id_q[NSTG-1];
    push_entry.op   = mul_op_t'(tag_op_q[NSTG-1]);
    push_entry.data = mul_p;
  end

  mul_rsp_fifo #(
    .RESP_DEPTH (RESP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head_entry),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  assign rsp_id   = head_entry.id;
  assign rsp_op   = head_entry.op;
  assign rsp_data = head_entry.data;

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (tag_vld_q[NSTG-1]) begin
        assert (mul_done && (mul_completed_op == tag_op_q[NSTG-1]))
          else $error("mul_arbiter: mul result does not match issued tag");
      end
      assert (!(push && fifo_full && !pop))
        else $error("mul_arbiter: response FIFO overflow");
      assert (fifo_count <= outstanding_q)
        else $error("mul_arbiter: buffered responses exceed credit count");
    end
  end

endmodule
